// File: rtl/pipe_pkg.sv
// pipe_pkg: shared defaults and bundle-width helper for the fetch/decode pipeline register
package pipe_pkg;
  localparam int DEF_PC_W = 32;
  localparam int DEF_INSTR_W = 32;
  localparam int DEF_LANES = 2;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  localparam int BUNDLE_W = DEF_PC_W + DEF_LANES * DEF_INSTR_W + DEF_LANES;
  function automatic int bundle_w(input int pc_w, input int instr_w, input int lanes);
    return pc_w + lanes * instr_w + lanes;
  endfunction
endpackage

// File: rtl/pipe_entry_reg.sv
// pipe_entry_reg: one bundle register with valid bit; clear restores the reset payload
module pipe_entry_reg #(
  parameter int W = 8,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic         vld,
  output logic [W-1:0] q
);
  logic         vld_d, vld_q;
  logic [W-1:0] q_d, q_q;
  always_comb begin
    vld_d = clr ? 1'b0 : load ? 1'b1 : vld_q;
    q_d   = clr ? RST : load ? d : q_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      q_q   <= RST;
    end else begin
      vld_q <= vld_d;
      q_q   <= q_d;
    end
  end
  assign vld = vld_q;
  assign q   = q_q;
endmodule

// File: rtl/if_id_skid_reg.sv
// if_id_skid_reg: fetch/decode bundle register with 2-entry skid buffer and stall/flush control
// Optional performance counters are built when IF_ID_SKID_PERF_EN is defined.
module if_id_skid_reg
  import pipe_pkg::*;
#(
  parameter int PC_W = DEF_PC_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int LANES = DEF_LANES,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_WORD)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall_i,
  input  logic                     flush_i,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [LANES*INSTR_W-1:0] in_instr,
  input  logic [LANES-1:0]         in_mask,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [LANES*INSTR_W-1:0] out_instr,
  output logic [LANES-1:0]         out_mask
`ifdef IF_ID_SKID_PERF_EN
  ,
  output logic [31:0]              perf_stall_cnt,
  output logic [31:0]              perf_bubble_cnt,
  output logic [31:0]              perf_flush_cnt
`endif
);
  localparam int BW = bundle_w(PC_W, INSTR_W, LANES);
  localparam logic [BW-1:0] RST_B = {{PC_W{1'b0}}, {LANES{NOP_INSTR}}, {LANES{1'b0}}};
  logic          main_vld, skid_vld, acc, drn;
  logic          main_load, main_clr, skid_load, skid_clr;
  logic          in_ready_d, in_ready_q;
  logic [BW-1:0] in_b, main_b, skid_b, main_d;
  assign in_b = {in_pc, in_instr, in_mask};
  // FULL never accepts because in_ready is low, so skid only fills from ONE.
  always_comb begin
    acc        = in_valid & in_ready_q & !stall_i & !flush_i;
    drn        = main_vld & out_ready & !stall_i & !flush_i;
    main_load  = (drn & skid_vld) | (acc & (!main_vld | drn));
    main_clr   = flush_i | (drn & !skid_vld & !acc);
    main_d     = skid_vld ? skid_b : in_b;
    skid_load  = acc & main_vld & !drn;
    skid_clr   = flush_i | (drn & skid_vld);
    in_ready_d = !skid_load & (!skid_vld | skid_clr);
  end
  pipe_entry_reg #(.W(BW), .RST(RST_B)) u_main (
    .clk(clk), .rst_n(rst_n), .load(main_load), .clr(main_clr),
    .d(main_d), .vld(main_vld), .q(main_b)
  );
  pipe_entry_reg #(.W(BW), .RST(RST_B)) u_skid (
    .clk(clk), .rst_n(rst_n), .load(skid_load), .clr(skid_clr),
    .d(in_b), .vld(skid_vld), .q(skid_b)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_ready_q <= 1'b1;
    else        in_ready_q <= in_ready_d;
  end
  assign in_ready  = in_ready_q;
  assign out_valid = main_vld;
  assign out_pc    = main_b[BW-1 -: PC_W];
  assign out_instr = main_b[LANES +: LANES*INSTR_W];
  assign out_mask  = main_b[LANES-1:0] & {LANES{main_vld}};
`ifdef IF_ID_SKID_PERF_EN
  logic [31:0] stall_cnt_d, stall_cnt_q, bubble_cnt_d, bubble_cnt_q, flush_cnt_d, flush_cnt_q;
  always_comb begin
    stall_cnt_d  = stall_cnt_q + 32'(stall_i);
    bubble_cnt_d = bubble_cnt_q + 32'(!main_vld & !stall_i);
    flush_cnt_d  = flush_cnt_q + 32'(flush_i);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end
  assign perf_stall_cnt  = stall_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
  assign perf_flush_cnt  = flush_cnt_q;
`endif
endmodule

// File: tb/tb_if_id_skid_reg.sv
// tb_if_id_skid_reg: randomized + directed scoreboard bench against a queue-based reference model
module tb_if_id_skid_reg;
  localparam int BW = 98;
  localparam logic [BW-1:0] RST_B = {32'h0, 32'h13, 32'h13, 2'b00};
  logic        clk = 0, rst_n = 0, stall_i = 0, flush_i = 0, in_valid = 0, out_ready = 0;
  logic        in_ready, out_valid;
  logic [31:0] in_pc = 0, out_pc;
  logic [63:0] in_instr = 0, out_instr;
  logic [1:0]  in_mask = 0, out_mask;
  int checks = 0, errors = 0;
  logic [BW-1:0] mq[$];
  logic [BW-1:0] exp_q[$];
`ifdef IF_ID_SKID_PERF_EN
  logic [31:0] perf_stall_cnt, perf_bubble_cnt, perf_flush_cnt;
  logic [31:0] m_stall = 0, m_bubble = 0, m_flush = 0;
`endif
  if_id_skid_reg dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .in_mask(in_mask), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .out_mask(out_mask)
`ifdef IF_ID_SKID_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_bubble_cnt(perf_bubble_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );
  always #5 clk = ~clk;
  function automatic void chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, a, e);
    end
  endfunction
  // Reference: the stage is a 2-deep FIFO; ready means fewer than two held bundles.
  always @(posedge clk or negedge rst_n) begin
    int n;
    if (!rst_n) begin
      mq.delete();
      exp_q.delete();
`ifdef IF_ID_SKID_PERF_EN
      m_stall = 0; m_bubble = 0; m_flush = 0;
`endif
    end else begin
      n = mq.size();
`ifdef IF_ID_SKID_PERF_EN
      m_stall  = m_stall + 32'(stall_i);
      m_bubble = m_bubble + 32'(n == 0 && !stall_i);
      m_flush  = m_flush + 32'(flush_i);
`endif
      if (flush_i) begin
        mq.delete();
        exp_q.delete();
      end else if (!stall_i) begin
        if (n > 0 && out_ready) void'(mq.pop_front());
        if (in_valid && n < 2) begin
          mq.push_back({in_pc, in_instr, in_mask});
          exp_q.push_back({in_pc, in_instr, in_mask});
        end
      end
    end
  end
  always @(negedge clk) begin
    #1;
    chk("out_valid", 128'(out_valid), 128'(mq.size() > 0));
    chk("in_ready", 128'(in_ready), 128'(mq.size() < 2));
    if (out_valid) begin
      if (exp_q.size() == 0) chk("unexpected_output", 128'({out_pc, out_instr, out_mask}), 128'(RST_B));
      else begin
        chk("out_bundle", 128'({out_pc, out_instr, out_mask}), 128'(exp_q[0]));
        if (out_ready && !stall_i && !flush_i) void'(exp_q.pop_front());
      end
    end else chk("idle_bundle", 128'({out_pc, out_instr, out_mask}), 128'(RST_B));
`ifdef IF_ID_SKID_PERF_EN
    chk("perf_stall", 128'(perf_stall_cnt), 128'(m_stall));
    chk("perf_bubble", 128'(perf_bubble_cnt), 128'(m_bubble));
    chk("perf_flush", 128'(perf_flush_cnt), 128'(m_flush));
`endif
  end
  task automatic cyc(input logic v, input logic [31:0] pc, input logic ordy, input logic st, input logic fl);
    @(negedge clk);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = {$urandom(), $urandom()};
    in_mask   = 2'($urandom_range(0, 3));
    out_ready = ordy;
    stall_i   = st;
    flush_i   = fl;
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 1, 0, 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_bundle", 128'({out_pc, out_instr, out_mask}), 128'(RST_B));
    cyc(1, 32'h100, 1, 0, 0);
    cyc(1, 32'h108, 1, 0, 0);
    cyc(1, 32'h110, 1, 0, 0);
    idle(3);
    cyc(1, 32'h100, 0, 0, 0);
    cyc(1, 32'h108, 0, 0, 0);
    cyc(1, 32'h110, 0, 0, 0);
    cyc(1, 32'h110, 1, 0, 0);
    idle(3);
    cyc(1, 32'h100, 0, 0, 0);
    cyc(1, 32'h108, 0, 0, 0);
    repeat (3) cyc(1, 32'h110, 1, 1, 0);
    cyc(1, 32'h110, 1, 0, 0);
    idle(3);
    cyc(1, 32'h100, 0, 0, 0);
    cyc(1, 32'h108, 0, 0, 0);
    cyc(1, 32'h200, 1, 0, 1);
    idle(2);
    cyc(1, 32'h300, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    rst_n = 0;
    #1;
    chk("async_out_valid", 128'(out_valid), 128'(0));
    chk("async_in_ready", 128'(in_ready), 128'(1));
    chk("async_bundle", 128'({out_pc, out_instr, out_mask}), 128'(RST_B));
`ifdef IF_ID_SKID_PERF_EN
    chk("async_perf", 128'({perf_stall_cnt, perf_bubble_cnt, perf_flush_cnt}), 128'(0));
`endif
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 800; i++)
      cyc(1'($urandom_range(0, 3) != 0), $urandom(), 1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 19) == 0));
    idle(4);
    @(negedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_id_skid_reg.md
Name: if_id_skid_reg

Overview:
- Parametrised successor to the fetch/decode pipeline register.
- Carries the PC plus LANES fetched instruction words with a per-lane valid mask, between fetch (upstream) and decode (downstream).
- Uses a valid/ready handshake with a 2-entry skid buffer, so in_ready is registered and throughput stays at one bundle per cycle.
- Keeps hazard-unit stall/flush control. Flush inserts NOP bubbles rather than zeros.

Parameters:
- PC_W, 32, PC width in bits.
- INSTR_W, 32, instruction word width in bits.
- LANES, 2, instructions per fetch bundle (>=1).
- NOP_INSTR, 32'h0000_0013, word loaded into every lane on reset/flush (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall_i  in  1  hazard stall: freeze stage, no accept, no drain.
- flush_i  in  1  hazard flush: discard all held and incoming bundles.
- in_valid  in  1  fetch bundle valid.
- in_ready  out  1  stage can accept (registered).
- in_pc  in  PC_W  bundle PC.
- in_instr  in  LANES*INSTR_W  lane i at [i*INSTR_W +: INSTR_W].
- in_mask  in  LANES  per-lane instruction valid.
- out_valid  out  1  decode bundle valid.
- out_ready  in  1  decode accepts.
- out_pc  out  PC_W  held PC.
- out_instr  out  LANES*INSTR_W  held instructions.
- out_mask  out  LANES  held lane mask.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: out_valid=0, in_ready=1, out_pc=0, every out_instr lane=NOP_INSTR, out_mask=0. Skid entry invalid, with the same cleared payload.
- Storage: a main entry (drives out_*) and a skid entry.
- Occupancy states:
  - EMPTY: main invalid.
  - ONE: main valid, skid invalid.
  - FULL: both valid.
- in_ready is 1 exactly when skid is invalid. It is a registered output with no combinational path from out_ready.
- Transfer conditions:
  - acc = in_valid & in_ready & !stall_i & !flush_i.
  - drn = out_valid & out_ready & !stall_i & !flush_i.
- EMPTY: acc loads main and moves to ONE.
- ONE:
  - acc & drn: main <= input, stay ONE.
  - drn only: go to EMPTY.
  - acc & !drn: skid <= input, go to FULL.
- FULL: in_ready=0. drn moves skid to main and goes to ONE. Input is never accepted in FULL, even in the same cycle as drn.
- Latency: an input accepted in cycle N appears on out_* in cycle N+1 when the stage was EMPTY or draining. Ordering is strictly FIFO.
- stall_i=1: all state holds and no transfers occur. out_valid keeps its value. Upstream/downstream must treat out_ready/in_valid as don't-care that cycle.
- flush_i=1: takes priority over stall_i and over a simultaneous in_valid. On the next edge both entries are invalid, the payload is restored to reset values, and in_ready=1. The flushed input bundle is dropped.
- out_mask is forced to 0 whenever out_valid=0. A bundle with in_mask=0 is still a legal transfer and is passed through.
- Reset asserted mid-operation: immediate clear to reset values regardless of the clock.

Optional Feature:
- Macro: IF_ID_SKID_PERF_EN.
- When defined, adds outputs perf_stall_cnt[31:0], perf_bubble_cnt[31:0] and perf_flush_cnt[31:0].
- Each counter resets to 0 and wraps modulo 2^32.
  - perf_stall_cnt: increments each cycle stall_i=1.
  - perf_bubble_cnt: increments each cycle out_valid=0 & !stall_i.
  - perf_flush_cnt: increments per flush_i cycle.
- When undefined, the ports and counters are absent and core behaviour is identical.

Decomposition:
- Package pipe_pkg holds: the default NOP constant, the default PC_W/INSTR_W, and a localparam for the bundle width (PC_W + LANES*INSTR_W + LANES).
- One sub-module is natural: pipe_entry_reg, a single bundle register with load/clear/hold controls and the reset payload. It is instantiated twice (main, skid).

Test Plan:
- Reset, then rst_n released: out_valid=0, in_ready=1, out_instr lanes=0x00000013, out_pc=0, out_mask=0.
- Streaming with out_ready=1: bundles PC 0x100, 0x108, 0x110 on consecutive cycles appear on consecutive cycles one cycle later. No bubbles.
- Backpressure: out_ready=0 with two bundles sent. Second goes to skid, in_ready drops to 0 and the third is held off. Raise out_ready: outputs 0x100, 0x108, 0x110 in order.
- stall_i=1 for 3 cycles while in FULL: outputs, in_ready and contents unchanged. After release, draining resumes in order.
- flush_i with in_valid=1 (PC 0x200) while FULL: next cycle out_valid=0, in_ready=1, lanes=NOP. PC 0x200 is never output.
- rst_n pulsed low mid-cycle while ONE: outputs clear immediately without a clock edge. Under IF_ID_SKID_PERF_EN, all counters read 0.
